// File: rtl/cclu_pkg.sv
// Shared types for the CCLU command sequencer: command encoding, FSM states
// and the instruction FIFO entry layout.
package cclu_pkg;

    localparam int unsigned CCLU_AW = 32;
    localparam int unsigned CCLU_CW = 32;

    typedef enum logic [1:0] {
        NOP  = 2'b00,
        LOOP = 2'b01,
        END  = 2'b10,
        CLR  = 2'b11
    } cclu_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_TGT,
        S_HALT
    } seq_state_e;

    typedef struct packed {
        cclu_cmd_e            op;
        logic [CCLU_AW-1:0]   pc;
        logic [CCLU_AW-1:0]   target;
        logic [CCLU_CW-1:0]   count;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/cclu_seq_fifo.sv
// Instruction FIFO: power-of-two depth, registered occupancy, synchronous flush.
module cclu_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cclu_cmd_sequencer.sv
// Issues buffered loop instructions to the CCLU one at a time and returns one
// response per instruction. Optional CCLU_SEQ_ZERO_FILTER_EN answers zero-count
// LOOPs locally with an error instead of issuing them.
module cclu_cmd_sequencer
    import cclu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned CW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_pc,
    input  logic [AW-1:0] in_target,
    input  logic [CW-1:0] in_count,
    output logic [1:0]    command,
    output logic [AW-1:0] addres_in,
    output logic [AW-1:0] target_in,
    output logic [CW-1:0] counter_in,
    input  logic          cclu_valid,
    input  logic          cclu_full,
    input  logic          cclu_error,
    input  logic [AW-1:0] cclu_target,
    output logic          rsp_valid,
    output logic          rsp_error,
    output logic [AW-1:0] rsp_target,
    output logic          halted,
    input  logic          err_clr
);

    seq_state_e  state_q, state_d;
    fifo_entry_t wr_entry, head;
    logic        fifo_full, fifo_empty;
    logic        push, pop, issue, capture;
    logic        zf_q, zf_d;

    // Response timing is fixed by the CCLU latency, so cclu_valid is not needed.
    logic unused_cclu_valid;
    assign unused_cclu_valid = cclu_valid;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full && (in_op == LOOP || in_op == END);
    assign wr_entry = '{op:     cclu_cmd_e'(in_op),
                        pc:     CCLU_AW'(in_pc),
                        target: CCLU_AW'(in_target),
                        count:  CCLU_CW'(in_count)};

    cclu_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (err_clr),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state and per-cycle controls; err_clr overrides everything.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        zf_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
`ifdef CCLU_SEQ_ZERO_FILTER_EN
                    if (head.op == LOOP && head.count == '0) begin
                        pop  = 1'b1;
                        zf_d = 1'b1;
                    end else
`endif
                    if (!(head.op == LOOP && cclu_full)) begin
                        pop     = 1'b1;
                        issue   = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                if (cclu_error) begin
                    rsp_valid = 1'b1;
                    rsp_error = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    capture = 1'b1;
                    state_d = S_TGT;
                end
            end
            S_TGT: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (zf_q) begin
            rsp_valid = 1'b1;
            rsp_error = 1'b1;
        end
        if (err_clr) begin
            state_d   = S_IDLE;
            pop       = 1'b0;
            issue     = 1'b0;
            capture   = 1'b0;
            rsp_valid = 1'b0;
            rsp_error = 1'b0;
            zf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            command    <= 2'b00;
            addres_in  <= '0;
            target_in  <= '0;
            counter_in <= '0;
            rsp_target <= '0;
            halted     <= 1'b0;
            zf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            command <= issue ? 2'(head.op) : 2'(NOP);
            if (issue) begin
                addres_in  <= AW'(head.pc);
                target_in  <= AW'(head.target);
                counter_in <= CW'(head.count);
            end
            if (capture) rsp_target <= cclu_target;
            halted <= (state_d == S_HALT);
            zf_q   <= zf_d;
        end
    end

endmodule

// File: tb/tb_cclu_cmd_sequencer.sv
// Self-checking bench for cclu_cmd_sequencer: directed scenarios plus a
// randomized run checked against an instruction-queue reference model.
module tb_cclu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned CW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_pc, in_target;
    logic [CW-1:0] in_count;
    logic [1:0]    command;
    logic [AW-1:0] addres_in, target_in;
    logic [CW-1:0] counter_in;
    logic          cclu_valid, cclu_full, cclu_error;
    logic [AW-1:0] cclu_target;
    logic          rsp_valid, rsp_error;
    logic [AW-1:0] rsp_target;
    logic          halted, err_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [1:0] op; logic [31:0] pc; logic [31:0] tgt; logic [31:0] cnt; } instr_t;
    typedef struct { int due; logic err; logic [31:0] tgt; } rsp_t;

    cclu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_pc(in_pc), .in_target(in_target), .in_count(in_count),
        .command(command), .addres_in(addres_in), .target_in(target_in),
        .counter_in(counter_in), .cclu_valid(cclu_valid), .cclu_full(cclu_full),
        .cclu_error(cclu_error), .cclu_target(cclu_target), .rsp_valid(rsp_valid),
        .rsp_error(rsp_error), .rsp_target(rsp_target), .halted(halted),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 1'b0; in_op = 2'b00; in_pc = '0; in_target = '0; in_count = '0;
        cclu_valid = 1'b0; cclu_full = 1'b0; cclu_error = 1'b0; cclu_target = '0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Offers one instruction for a single cycle; returns 1 ns into the next cycle.
    task automatic push(input logic [1:0] op, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] cnt);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_target = tgt; in_count = cnt;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1'b1; in_op = 2'b01; in_pc = 32'h55; in_count = 32'd7;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || command !== 2'b00 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hs in_ready=%0b cmd=%0h rsp_valid=%0b exp 1/0/0", in_ready, command, rsp_valid);
            end
        end
        checks++;
        if (addres_in !== '0 || target_in !== '0 || counter_in !== '0 || rsp_target !== '0 ||
            rsp_error !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals addr=%0h tgt=%0h cnt=%0h rtgt=%0h rerr=%0b halted=%0b exp all 0",
                     addres_in, target_in, counter_in, rsp_target, rsp_error, halted);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        push(2'b01, 32'h100, 32'h200, 32'd3);
        @(negedge clk);
        checks++;
        if (command !== 2'b00) begin failures++; $display("FAIL lat_n1 cmd=%0h exp 0", command); end
        @(negedge clk);
        checks++;
        if (command !== 2'b01 || addres_in !== 32'h100 || target_in !== 32'h200 || counter_in !== 32'd3) begin
            failures++;
            $display("FAIL lat_issue cmd=%0h addr=%0h tgt=%0h cnt=%0h exp 1/100/200/3", command, addres_in, target_in, counter_in);
        end
        @(posedge clk); #1;
        cclu_valid = 1'b1; cclu_target = 32'h200; cclu_error = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || command !== 2'b00) begin
            failures++; $display("FAIL lat_n3 rsp_valid=%0b cmd=%0h exp 0/0", rsp_valid, command);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_target !== 32'h200) begin
            failures++;
            $display("FAIL lat_rsp valid=%0b err=%0b tgt=%0h exp 1/0/200", rsp_valid, rsp_error, rsp_target);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || addres_in !== 32'h100 || counter_in !== 32'd3) begin
            failures++;
            $display("FAIL lat_after valid=%0b addr=%0h cnt=%0h exp 0/100/3", rsp_valid, addres_in, counter_in);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(2'b01, 32'h111, 32'h222, 32'd4);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (command !== 2'b00 || addres_in !== '0 || counter_in !== '0) begin
            failures++;
            $display("FAIL reset_mid cmd=%0h addr=%0h cnt=%0h exp 0/0/0", command, addres_in, counter_in);
        end
        @(posedge clk); #1;
        reset = 1'b1; cclu_target = 32'h222;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || command !== 2'b00) begin
                failures++; $display("FAIL reset_mid_quiet rsp_valid=%0b cmd=%0h exp 0/0", rsp_valid, command);
            end
        end
    endtask

    task automatic test_halt_fill();
        do_reset();
        push(2'b01, 32'h10, 32'h20, 32'd5);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        cclu_error = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_rsp valid=%0b err=%0b halted=%0b exp 1/1/0", rsp_valid, rsp_error, halted);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag halted=%0b exp 1", halted); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = (i % 2 == 1) ? 2'b10 : 2'b01;
            in_pc = 32'(i); in_target = 32'(i + 8); in_count = 32'(i + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || halted !== 1'b1) begin
            failures++; $display("FAIL halt_full in_ready=%0b halted=%0b exp 0/1", in_ready, halted);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (command !== 2'b00) begin failures++; $display("FAIL halt_noissue cmd=%0h exp 0", command); end
        end
        @(posedge clk); #1;
        err_clr = 1'b1; cclu_error = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL clr_rsp rsp_valid=%0b exp 0", rsp_valid); end
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || halted !== 1'b0) begin
            failures++; $display("FAIL clr_state in_ready=%0b halted=%0b exp 1/0", in_ready, halted);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (command !== 2'b00 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL clr_flushed cmd=%0h rsp_valid=%0b exp 0/0", command, rsp_valid);
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        cclu_full = 1'b1;
        push(2'b01, 32'h30, 32'h40, 32'd9);
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (command !== 2'b00) begin failures++; $display("FAIL stall_loop cmd=%0h exp 0", command); end
        end
        @(posedge clk); #1;
        cclu_full = 1'b0;
        @(negedge clk);
        checks++;
        if (command !== 2'b00) begin failures++; $display("FAIL stall_release cmd=%0h exp 0", command); end
        @(negedge clk);
        checks++;
        if (command !== 2'b01 || addres_in !== 32'h30) begin
            failures++; $display("FAIL stall_issue cmd=%0h addr=%0h exp 1/30", command, addres_in);
        end
        @(posedge clk); #1;
        cclu_target = 32'h40;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_target !== 32'h40) begin
            failures++; $display("FAIL stall_rsp valid=%0b tgt=%0h exp 1/40", rsp_valid, rsp_target);
        end
        cclu_full = 1'b1;
        push(2'b10, 32'h90, 32'ha0, 32'd1);
        repeat (2) @(negedge clk);
        checks++;
        if (command !== 2'b10 || addres_in !== 32'h90) begin
            failures++; $display("FAIL end_full cmd=%0h addr=%0h exp 2/90", command, addres_in);
        end
        @(posedge clk); #1;
        cclu_target = 32'h77;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_target !== 32'h77) begin
            failures++; $display("FAIL end_rsp valid=%0b err=%0b tgt=%0h exp 1/0/77", rsp_valid, rsp_error, rsp_target);
        end
    endtask

    task automatic test_op_discard();
        do_reset();
        push(2'b11, 32'h1, 32'h2, 32'd3);
        push(2'b00, 32'h4, 32'h5, 32'd6);
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (command !== 2'b00 || rsp_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL discard cmd=%0h rsp_valid=%0b in_ready=%0b exp 0/0/1", command, rsp_valid, in_ready);
            end
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        push(2'b01, 32'h50, 32'h60, 32'd0);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL zero_n1 rsp_valid=%0b exp 0", rsp_valid); end
        @(negedge clk);
        checks++;
`ifdef CCLU_SEQ_ZERO_FILTER_EN
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || command !== 2'b00) begin
            failures++; $display("FAIL zero_filter valid=%0b err=%0b cmd=%0h exp 1/1/0", rsp_valid, rsp_error, command);
        end
`else
        if (command !== 2'b01 || counter_in !== 32'd0) begin
            failures++; $display("FAIL zero_issue cmd=%0h cnt=%0h exp 1/0", command, counter_in);
        end
`endif
        @(posedge clk); #1;
        cclu_error = 1'b1;
        @(negedge clk);
        checks++;
`ifdef CCLU_SEQ_ZERO_FILTER_EN
        if (rsp_valid !== 1'b0 || command !== 2'b00) begin
            failures++; $display("FAIL zero_filter_quiet valid=%0b cmd=%0h exp 0/0", rsp_valid, command);
        end
`else
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
            failures++; $display("FAIL zero_err valid=%0b err=%0b exp 1/1", rsp_valid, rsp_error);
        end
`endif
        @(negedge clk);
        checks++;
`ifdef CCLU_SEQ_ZERO_FILTER_EN
        if (halted !== 1'b0) begin failures++; $display("FAIL zero_halt halted=%0b exp 0", halted); end
`else
        if (halted !== 1'b1) begin failures++; $display("FAIL zero_halt halted=%0b exp 1", halted); end
`endif
    endtask

    // Random traffic against an in-order instruction queue and a CCLU that
    // answers one cycle after every command it sees.
    task automatic test_random();
        instr_t      q[$];
        rsp_t        pend[$];
        logic        halted_m, halt_next, prev_full, drv_rsp, nx_err, exp_v, exp_rdy, drained, drain;
        logic [31:0] nx_tgt;
        int          last_cmd, r;
        halted_m = 1'b0; prev_full = 1'b0; drv_rsp = 1'b0; nx_err = 1'b0; nx_tgt = '0;
        drained = 1'b0; last_cmd = -100;
        do_reset();
        for (int k = 0; k < 1800; k++) begin
            drain = (k >= 1400);
            @(posedge clk); #1;
            cclu_valid = drv_rsp;
            if (drv_rsp) begin cclu_error = nx_err; cclu_target = nx_tgt; drv_rsp = 1'b0; end
            cclu_full = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
            if (halted_m) err_clr = ($urandom_range(0, drain ? 2 : 5) == 0);
            else          err_clr = !drain && ($urandom_range(0, 49) == 0);
            in_valid = !drain && !err_clr && ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 9));
            in_op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            in_pc = $urandom; in_target = $urandom;
`ifdef CCLU_SEQ_ZERO_FILTER_EN
            in_count = $urandom_range(1, 1000);
`else
            in_count = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 1000);
`endif
            @(negedge clk);
            if (command !== 2'b00) begin
                checks++;
                if (halted_m || q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_cmd_unexpected cyc=%0d cmd=%0h model_halted=%0b queued=%0d", k, command, halted_m, q.size());
                end else begin
                    if (command !== q[0].op || addres_in !== q[0].pc || target_in !== q[0].tgt || counter_in !== q[0].cnt) begin
                        failures++;
                        $display("FAIL rnd_cmd cyc=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", k, command, addres_in,
                                 target_in, counter_in, q[0].op, q[0].pc, q[0].tgt, q[0].cnt);
                    end
                    checks++;
                    if (command === 2'b01 && prev_full) begin
                        failures++; $display("FAIL rnd_full_stall cyc=%0d LOOP issued after full=1 exp stall", k);
                    end
                    checks++;
                    if (k - last_cmd < 4) begin
                        failures++; $display("FAIL rnd_gap cyc=%0d gap=%0d exp >=4", k, k - last_cmd);
                    end
                    nx_err  = (q[0].cnt == 32'd0) || ($urandom_range(0, 4) == 0);
                    nx_tgt  = $urandom;
                    drv_rsp = 1'b1;
                    pend.push_back('{due: k + (nx_err ? 1 : 2), err: nx_err, tgt: nx_tgt});
                    q.delete(0);
                end
                last_cmd = k;
            end
            exp_v     = (pend.size() > 0) && (pend[0].due == k) && !err_clr;
            halt_next = exp_v && pend[0].err;
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%0b exp=%0b", k, rsp_valid, exp_v);
            end else if (exp_v) begin
                checks++;
                if (rsp_error !== pend[0].err || (!pend[0].err && rsp_target !== pend[0].tgt)) begin
                    failures++;
                    $display("FAIL rnd_rsp_data cyc=%0d err=%0b tgt=%0h exp err=%0b tgt=%0h", k, rsp_error, rsp_target,
                             pend[0].err, pend[0].tgt);
                end
            end
            if (pend.size() > 0 && pend[0].due == k) pend.delete(0);
            checks++;
            if (halted !== halted_m) begin
                failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", k, halted, halted_m);
            end
            exp_rdy = (q.size() < DEPTH);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", k, in_ready, exp_rdy);
            end
            if (err_clr) begin
                q.delete(); pend.delete(); last_cmd = -100;
            end else if (in_valid && exp_rdy && (in_op == 2'b01 || in_op == 2'b10)) begin
                q.push_back('{op: in_op, pc: in_pc, tgt: in_target, cnt: in_count});
            end
            halted_m  = err_clr ? 1'b0 : (halted_m | halt_next);
            prev_full = cclu_full;
            if (drain && q.size() == 0 && pend.size() == 0 && !halted_m) begin
                drained = 1'b1;
                break;
            end
        end
        checks++;
        if (!drained) begin
            failures++; $display("FAIL rnd_drain queued=%0d pending=%0d exp 0/0 within budget", q.size(), pend.size());
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_reset_mid();
        test_halt_fill();
        test_full_stall();
        test_op_discard();
        test_zero_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cclu_cmd_sequencer.md
# cclu_cmd_sequencer

Command issue stage that sits directly upstream of the CCLU loop-control unit. It accepts decoded loop instructions over a valid/ready handshake and buffers them in a small FIFO. It drives one CCLU command at a time (command/address/target/counter), waits out the CCLU's registered response latency, and returns one response per instruction (target or error) to the fetch side. It stalls on CCLU full and halts on CCLU error until explicitly cleared.

## Interface
Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)
- AW, 32, address/target width
- CW, 32, loop count width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO not full; transfer when in_valid && in_ready
- in_op  in  2  01 LOOP, 10 END; 00/11 accepted and discarded
- in_pc  in  AW  loop instruction address
- in_target  in  AW  loop body target
- in_count  in  CW  iteration count
- command  out  2  to CCLU command
- addres_in  out  AW  to CCLU
- target_in  out  AW  to CCLU
- counter_in  out  CW  to CCLU
- cclu_valid  in  1  CCLU valid
- cclu_full  in  1  CCLU isFull
- cclu_error  in  1  CCLU error
- cclu_target  in  AW  CCLU target_out
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  qualifies rsp_valid: instruction failed
- rsp_target  out  AW  valid with rsp_valid && !rsp_error
- halted  out  1  sequencer in HALT
- err_clr  in  1  leave HALT, flush FIFO

## Operation
- FIFO: DEPTH entries of {op, pc, target, count}; simultaneous push and pop allowed when full (pop frees the slot in the same cycle only for the next cycle's in_ready; in_ready = !full, registered count).
- Ops 00/11 are never written to the FIFO.
- FSM states: IDLE, ISSUE, RESP, TGT, HALT.
  - IDLE: when the FIFO is non-empty, go to ISSUE and pop the head, unless head op == LOOP && cclu_full (stall in IDLE). END never stalls on full.
  - ISSUE: drive command = head op and the operands for exactly one cycle, then go to RESP.
  - RESP: sample cclu_error. If it is 1, pulse rsp_valid with rsp_error=1 and go to HALT. Otherwise go to TGT.
  - TGT: capture cclu_target into rsp_target, pulse rsp_valid (rsp_error=0), go to IDLE.
  - HALT: command=00; FIFO keeps accepting until full; no issue.
- err_clr has priority in every state:
  - FSM goes to IDLE and the FIFO is emptied.
  - Any in-flight response is dropped (no rsp_valid).
  - command is 00 the next cycle.
- In all non-ISSUE cycles: command=00; operand outputs hold their last values.
- in_count is passed unmodified (no width change, no decrement).

## Timing
- Reset values: command=00, addres_in/target_in/counter_in=0, rsp_valid=0, rsp_error=0, rsp_target=0, halted=0, in_ready=1, FSM=IDLE, FIFO empty.
- Latency:
  - Accepted into an empty idle unit in cycle N: command driven in N+2.
  - Error response in N+3; target response in N+4.
- Throughput: one instruction per 4 cycles (IDLE, ISSUE, RESP, TGT).
- cclu_full is sampled in IDLE only.
- HALT asserts halted from the cycle after the error response.
- reset low mid-operation returns immediately to the reset values, with no response for in-flight instructions.

## Configuration
- CCLU_SEQ_ZERO_FILTER_EN defined: a LOOP with count == 0 reaching the FIFO head is not issued. It is popped in IDLE and answered next cycle with rsp_valid=1, rsp_error=1, and the FSM stays out of HALT.
- Not defined: count 0 is issued to the CCLU and the CCLU's error drives HALT.

## Structure
- Shared package cclu_pkg holds:
  - cclu_cmd_e (NOP=00, LOOP=01, END=10, CLR=11)
  - seq_state_e
  - fifo entry struct typedef
- One sub-module: cclu_seq_fifo (parameterised DEPTH/width, full/empty, flush input).

## Test plan
- Reset low with in_valid=1 → in_ready=1, command=00, no response; release, then push LOOP pc=0x100 target=0x200 count=3 → command=01 two cycles later; cclu_target=0x200 → rsp_valid, rsp_target=0x200 at N+4.
- Push 4 instructions back-to-back (DEPTH=4) while HALT → in_ready=0 after the 4th; err_clr → FIFO empty, in_ready=1, no rsp_valid.
- cclu_full=1 with LOOP at head → command stays 00; deassert → command=01 the next ISSUE; END at head with full=1 → issued.
- cclu_error=1 in RESP → rsp_valid=1, rsp_error=1, halted=1; later FIFO contents not issued until err_clr.
- LOOP count=0 with CCLU_SEQ_ZERO_FILTER_EN → command never 01, rsp_error pulse, halted=0; without the macro → command=01, then HALT on CCLU error.
- in_op=11 offered → accepted, no command, no response.
